// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
// Optional starvation guard is enabled with the macro MEM_ARB_STARVE_GUARD_EN.
package mem_arb_pkg;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2,
        ST_DONE   = 2'd3
    } arb_state_t;

    // Number of byte lanes for a given data width.
    function automatic int be_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch port, load/store port and memory command signals.
// The arbiter sits on the slave modport; requesters and memory use master.
import mem_arb_pkg::*;

interface mem_arbiter_if #(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W
);
    localparam int BE_W = be_width(DATA_W);

    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic [DATA_W-1:0] i_rdata;
    logic              i_stall;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [BE_W-1:0]   d_be;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic              d_stall;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_be;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport slave (
        input  i_req, i_addr,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        input  mem_rdata, mem_ready,
        output i_ack, i_rdata, i_stall,
        output d_ack, d_rdata, d_stall,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport master (
        output i_req, i_addr,
        output d_req, d_we, d_addr, d_wdata, d_be,
        output mem_rdata, mem_ready,
        input  i_ack, i_rdata, i_stall,
        input  d_ack, d_rdata, d_stall,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

endinterface

// File: rtl/mem_arbiter_starve_ctr.sv
// Starvation counter for the fetch port. The module only exists when
// MEM_ARB_STARVE_GUARD_EN is defined, matching its conditional instantiation.
`ifdef MEM_ARB_STARVE_GUARD_EN
module mem_arb_starve_ctr #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_req,
    input  logic grant_i,
    input  logic grant_d,
    output logic force_i
);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] cnt;

    // Count D grants that happen while fetch is waiting; saturate at the limit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (grant_i || !i_req) begin
            cnt <= '0;
        end else if (grant_d && (cnt != CNT_W'(STARVE_LIMIT))) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Qualified with i_req so a dropped fetch never blocks a D grant.
    always_comb begin
        force_i = i_req && (cnt >= CNT_W'(STARVE_LIMIT));
    end

endmodule
`endif

// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) arbiter in front of a single-port memory.
// D has fixed priority over I; with MEM_ARB_STARVE_GUARD_EN defined, I is
// forced through after STARVE_LIMIT consecutive D grants while it waits.
//
// state     | meaning
// ----------+--------------------------------------------------------
// ST_IDLE   | no transaction; arbitrate between d_req and i_req
// ST_BUSY_I | fetch command on memory bus, waiting for mem_ready
// ST_BUSY_D | load/store command on memory bus, waiting for mem_ready
// ST_DONE   | one-cycle ack to the served port; no arbitration
import mem_arb_pkg::*;

module mem_arbiter #(
    parameter int ADDR_W       = ARB_ADDR_W,
    parameter int DATA_W       = ARB_DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input logic           clk,
    input logic           rst,
    mem_arbiter_if.slave  bus
);
    localparam int BE_W = be_width(DATA_W);

    arb_state_t state;
    arb_state_t state_nxt;

    logic grant_i;
    logic grant_d;
    logic mem_done;
    logic force_i;

    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [BE_W-1:0]   mem_be_q;
    logic              i_ack_q;
    logic              d_ack_q;
    logic [DATA_W-1:0] i_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

`ifdef MEM_ARB_STARVE_GUARD_EN
    mem_arb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk     (clk),
        .rst     (rst),
        .i_req   (bus.i_req),
        .grant_i (grant_i),
        .grant_d (grant_d),
        .force_i (force_i)
    );
`else
    localparam int STARVE_LIMIT_UNUSED = STARVE_LIMIT;
    assign force_i = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus one-cycle grant/completion strobes.
    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        mem_done  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.d_req && !force_i) begin
                    grant_d   = 1'b1;
                    state_nxt = ST_BUSY_D;
                end else if (bus.i_req) begin
                    grant_i   = 1'b1;
                    state_nxt = ST_BUSY_I;
                end
            end
            ST_BUSY_I, ST_BUSY_D: begin
                if (bus.mem_ready) begin
                    mem_done  = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Memory command: latched from the winner on the grant edge, held until done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
        end else if (grant_d) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= bus.d_we;
            mem_addr_q  <= bus.d_addr;
            mem_wdata_q <= bus.d_wdata;
            mem_be_q    <= bus.d_be;
        end else if (grant_i) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= bus.i_addr;
            mem_wdata_q <= '0;
            mem_be_q    <= {BE_W{1'b1}};
        end else if (mem_done) begin
            mem_req_q   <= 1'b0;
        end
    end

    // Completion: capture read data for the served port and raise its ack for DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            i_ack_q <= mem_done && (state == ST_BUSY_I);
            d_ack_q <= mem_done && (state == ST_BUSY_D);
            if (mem_done && (state == ST_BUSY_I)) begin
                i_rdata_q <= bus.mem_rdata;
            end
            if (mem_done && (state == ST_BUSY_D)) begin
                d_rdata_q <= bus.mem_rdata;
            end
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.i_ack     = i_ack_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.i_stall   = bus.i_req & ~i_ack_q;
    assign bus.d_stall   = bus.d_req & ~d_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, store, collision, starvation,
// async reset, input changes after grant, and stray mem_ready.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .STARVE_LIMIT (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    int          mem_lat     = 1;
    int          wait_cnt    = 0;
    logic        ready_model = 1'b0;
    logic        ready_force = 1'b0;
    logic [31:0] rdata_val   = '0;

    assign bus.mem_ready = ready_model | ready_force;
    assign bus.mem_rdata = rdata_val;

    // Memory model: ready pulses in the mem_lat-th cycle mem_req is high.
    always @(negedge clk) begin
        ready_model = 1'b0;
        if (!bus.mem_req) begin
            wait_cnt = 0;
        end else begin
            wait_cnt++;
            if (wait_cnt == mem_lat) ready_model = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] cmd();
        return 128'({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be});
    endfunction

    function automatic logic [127:0] exp_cmd(input logic req, input logic we,
                                             input logic [31:0] a, input logic [31:0] w,
                                             input logic [3:0] be);
        return 128'({req, we, a, w, be});
    endfunction

    // Command without write data, for fetch grants where wdata has no meaning.
    function automatic logic [127:0] cmd_nowd();
        return 128'({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be});
    endfunction

    function automatic logic [127:0] acks();
        return 128'({bus.i_ack, bus.d_ack});
    endfunction

    task automatic idle_inputs();
        bus.i_req   = 1'b0;
        bus.i_addr  = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        bus.d_be    = '0;
    endtask

    initial begin
        int d_acks;
        int i_acks;
        int d_before_i;

        idle_inputs();

        // Reset state
        @(negedge clk);
        check("rst_cmd", cmd(), 128'h0);
        check("rst_acks", acks(), 128'h0);
        check("rst_rdata", 128'({bus.i_rdata, bus.d_rdata}), 128'h0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_release_cmd", cmd(), 128'h0);

        // Fetch, latency 1
        mem_lat   = 1;
        rdata_val = 32'hDEAD_BEEF;
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h100;
        @(negedge clk);
        check("t1_cmd", cmd_nowd(), 128'({1'b1, 1'b0, 32'h100, 4'hF}));
        check("t1_stall", 128'(bus.i_stall), 128'h1);
        check("t1_no_ack", acks(), 128'h0);
        @(negedge clk);
        check("t1_ack", acks(), 128'h2);
        check("t1_rdata", 128'(bus.i_rdata), 128'hDEAD_BEEF);
        check("t1_stall_ack", 128'(bus.i_stall), 128'h0);
        check("t1_req_drop", 128'(bus.mem_req), 128'h0);
        bus.i_req = 1'b0;
        @(negedge clk);
        check("t1_ack_gone", acks(), 128'h0);
        check("t1_stall_after", 128'(bus.i_stall), 128'h0);

        // Store, latency 3
        mem_lat     = 3;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h2000;
        bus.d_wdata = 32'h1234_5678;
        bus.d_be    = 4'b0011;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t2_cmd_stable", cmd(), exp_cmd(1'b1, 1'b1, 32'h2000, 32'h1234_5678, 4'b0011));
            check("t2_no_ack", acks(), 128'h0);
        end
        @(negedge clk);
        check("t2_ack", acks(), 128'h1);
        check("t2_req_drop", 128'(bus.mem_req), 128'h0);
        bus.d_req = 1'b0;
        @(negedge clk);
        check("t2_ack_once", acks(), 128'h0);

        // Simultaneous requests: D first, I right after D's DONE
        mem_lat     = 1;
        rdata_val   = 32'h1111_0000;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h300;
        bus.d_be    = 4'hF;
        bus.i_req   = 1'b1;
        bus.i_addr  = 32'h400;
        @(negedge clk);
        check("t3_d_cmd", cmd_nowd(), 128'({1'b1, 1'b0, 32'h300, 4'hF}));
        check("t3_stalls", 128'({bus.i_stall, bus.d_stall}), 128'h3);
        @(negedge clk);
        check("t3_d_ack", acks(), 128'h1);
        check("t3_d_rdata", 128'(bus.d_rdata), 128'h1111_0000);
        bus.d_req = 1'b0;
        rdata_val = 32'h2222_0000;
        @(negedge clk);
        check("t3_gap", 128'({bus.mem_req, bus.i_ack, bus.d_ack}), 128'h0);
        @(negedge clk);
        check("t3_i_cmd", cmd_nowd(), 128'({1'b1, 1'b0, 32'h400, 4'hF}));
        @(negedge clk);
        check("t3_i_ack", acks(), 128'h2);
        check("t3_i_rdata", 128'(bus.i_rdata), 128'h2222_0000);
        check("t3_d_rdata_hold", 128'(bus.d_rdata), 128'h1111_0000);
        bus.i_req = 1'b0;
        @(negedge clk);

        // Continuous D traffic with I waiting
        d_acks     = 0;
        i_acks     = 0;
        d_before_i = -1;
        rdata_val  = 32'h4444_4444;
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h800;
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h900;
`ifdef MEM_ARB_STARVE_GUARD_EN
        for (int c = 0; c < 30 && d_before_i < 0; c++) begin
            @(negedge clk);
            if (bus.d_ack) d_acks++;
            if (bus.i_ack) d_before_i = d_acks;
        end
        bus.d_req = 1'b0;
        bus.i_req = 1'b0;
        check("t4_d_grants_before_i", 128'(d_before_i), 128'd4);
`else
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (bus.d_ack) d_acks++;
            if (bus.i_ack) i_acks++;
        end
        bus.d_req = 1'b0;
        bus.i_req = 1'b0;
        check("t4_i_starved", 128'(i_acks), 128'd0);
        check("t4_d_grants", 128'(d_acks), 128'd8);
`endif
        @(negedge clk);
        @(negedge clk);
        check("t4_settled", 128'(bus.mem_req), 128'h0);

        // Async reset while BUSY_D with ready pending
        mem_lat    = 5;
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h700;
        bus.d_be   = 4'hF;
        @(negedge clk);
        check("t5_busy", 128'(bus.mem_req), 128'h1);
        @(negedge clk);
        rst       = 1'b0;
        bus.d_req = 1'b0;
        #1;
        check("t5_cmd_async", cmd(), 128'h0);
        check("t5_acks_async", acks(), 128'h0);
        check("t5_rdata_async", 128'({bus.i_rdata, bus.d_rdata}), 128'h0);
        @(negedge clk);
        rst = 1'b1;
        d_acks = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.d_ack || bus.mem_req) d_acks++;
        end
        check("t5_no_ack_after", 128'(d_acks), 128'd0);
        mem_lat    = 1;
        rdata_val  = 32'h5555_AAAA;
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h104;
        @(negedge clk);
        check("t5_idle_grant", cmd_nowd(), 128'({1'b1, 1'b0, 32'h104, 4'hF}));
        @(negedge clk);
        check("t5_idle_ack", acks(), 128'h2);
        bus.i_req = 1'b0;
        @(negedge clk);

        // Requester changes inputs and drops d_req after grant
        mem_lat     = 2;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h500;
        bus.d_wdata = 32'hAAAA_5555;
        bus.d_be    = 4'hF;
        @(negedge clk);
        bus.d_req   = 1'b0;
        bus.d_addr  = 32'h600;
        bus.d_wdata = 32'h0;
        bus.d_be    = 4'h1;
        bus.d_we    = 1'b0;
        #1;
        check("t6_stall_drop", 128'(bus.d_stall), 128'h0);
        @(negedge clk);
        check("t6_cmd_latched", cmd(), exp_cmd(1'b1, 1'b1, 32'h500, 32'hAAAA_5555, 4'hF));
        @(negedge clk);
        check("t6_ack", acks(), 128'h1);
        @(negedge clk);
        check("t6_ack_once", acks(), 128'h0);
        @(negedge clk);
        check("t6_no_regrant", 128'(bus.mem_req), 128'h0);

        // mem_ready while idle is ignored, then a normal load completes on time
        ready_force = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t7_stray_ready", 128'({bus.mem_req, bus.i_ack, bus.d_ack}), 128'h0);
        ready_force = 1'b0;
        mem_lat     = 2;
        rdata_val   = 32'h7777_1234;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'hA00;
        @(negedge clk);
        check("t7_no_early_ack", acks(), 128'h0);
        @(negedge clk);
        check("t7_no_early_ack2", acks(), 128'h0);
        @(negedge clk);
        check("t7_ack", acks(), 128'h1);
        check("t7_rdata", 128'(bus.d_rdata), 128'h7777_1234);
        bus.d_req = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
